// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit between the core datapath and the memory bus.
// Handles sized and extended accesses, byte enables, misalignment and ack timeout.
module load_store_unit #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req,
    input  logic                    we,
    input  logic [2:0]              funct3,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    misaligned,
    output logic                    bus_error,
    output logic                    memory_read,
    output logic                    memory_write,
    output logic [ADDR_WIDTH-1:0]   address,
    output logic [DATA_WIDTH-1:0]   write_data,
    output logic [DATA_WIDTH/8-1:0] byte_enable,
    input  logic [DATA_WIDTH-1:0]   read_data,
    input  logic                    ack
);
    localparam int unsigned BE_W   = DATA_WIDTH / 8;
    localparam int unsigned LANE_W = $clog2(BE_W);
    localparam int unsigned CNT_W  = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_busy, r_done, r_misaligned, r_bus_error, r_rd, r_wr;
    logic [DATA_WIDTH-1:0] r_rdata, r_wdata;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [BE_W-1:0]       r_be;
    logic                  r_we, r_zext;
    logic [1:0]            r_size;
    logic [LANE_W-1:0]     r_lane;
    logic [CNT_W-1:0]      r_cnt;

    logic                  w_busy_nxt, w_done_nxt, w_mis_nxt, w_berr_nxt, w_rd_nxt, w_wr_nxt;
    logic [DATA_WIDTH-1:0] w_rdata_nxt, w_wdata_nxt;
    logic [ADDR_WIDTH-1:0] w_address_nxt;
    logic [BE_W-1:0]       w_be_nxt;
    logic                  w_we_nxt, w_zext_nxt;
    logic [1:0]            w_size_nxt;
    logic [LANE_W-1:0]     w_lane_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;

    logic                  w_misaligned;
    logic [LANE_W-1:0]     w_lane;
    logic [BE_W-1:0]       w_be_mask;
    logic [DATA_WIDTH-1:0] w_wdata_rep;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic [DATA_WIDTH-1:0] w_load;

    assign w_lane = addr[LANE_W-1:0];

    // Request decode: alignment, lane mask and replicated store data
    always_comb begin
        w_misaligned = 1'b0;
        w_be_mask    = BE_W'(8'h01);
        w_wdata_rep  = wdata;
        case (funct3[1:0])
            2'd0: begin
                w_be_mask   = BE_W'(8'h01);
                w_wdata_rep = {BE_W{wdata[7:0]}};
            end
            2'd1: begin
                w_misaligned = addr[0];
                w_be_mask    = BE_W'(8'h03);
                w_wdata_rep  = {(BE_W/2){wdata[15:0]}};
            end
            2'd2: begin
                w_misaligned = |addr[1:0];
                w_be_mask    = BE_W'(8'h0F);
                w_wdata_rep  = {(BE_W/4){wdata[31:0]}};
            end
            default: begin
                // A double access cannot be served on a 32-bit bus at all
                w_misaligned = (DATA_WIDTH == 32) || (|addr[2:0]);
                w_be_mask    = BE_W'(8'hFF);
                w_wdata_rep  = wdata;
            end
        endcase
    end

    assign w_shifted = read_data >> {r_lane, 3'b000};

    // Load extraction from the latched size, lane and extension mode
    always_comb begin
        case (r_size)
            2'd0:    w_load = r_zext ? DATA_WIDTH'(w_shifted[7:0])
                                     : DATA_WIDTH'($signed(w_shifted[7:0]));
            2'd1:    w_load = r_zext ? DATA_WIDTH'(w_shifted[15:0])
                                     : DATA_WIDTH'($signed(w_shifted[15:0]));
            2'd2:    w_load = r_zext ? DATA_WIDTH'(w_shifted[31:0])
                                     : DATA_WIDTH'($signed(w_shifted[31:0]));
            default: w_load = w_shifted;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_misaligned <= 1'b0;
            r_bus_error  <= 1'b0;
            r_rd         <= 1'b0;
            r_wr         <= 1'b0;
            r_rdata      <= '0;
            r_wdata      <= '0;
            r_address    <= '0;
            r_be         <= '0;
            r_we         <= 1'b0;
            r_zext       <= 1'b0;
            r_size       <= 2'd0;
            r_lane       <= '0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_misaligned <= w_mis_nxt;
            r_bus_error  <= w_berr_nxt;
            r_rd         <= w_rd_nxt;
            r_wr         <= w_wr_nxt;
            r_rdata      <= w_rdata_nxt;
            r_wdata      <= w_wdata_nxt;
            r_address    <= w_address_nxt;
            r_be         <= w_be_nxt;
            r_we         <= w_we_nxt;
            r_zext       <= w_zext_nxt;
            r_size       <= w_size_nxt;
            r_lane       <= w_lane_nxt;
            r_cnt        <= w_cnt_nxt;
        end
    end

    // Next state; a misaligned request spends one strobe-free cycle in REQ
    // so its done lands at the same latency as the fastest bus access
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (req) w_state_nxt = S_REQ;
            S_REQ:   if (r_misaligned || ack || (r_cnt == CNT_LAST)) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of all registered outputs and request context
    always_comb begin
        w_busy_nxt    = (w_state_nxt != S_IDLE);
        w_done_nxt    = (w_state_nxt == S_DONE);
        w_mis_nxt     = r_misaligned;
        w_berr_nxt    = r_bus_error;
        w_rd_nxt      = r_rd;
        w_wr_nxt      = r_wr;
        w_rdata_nxt   = r_rdata;
        w_wdata_nxt   = r_wdata;
        w_address_nxt = r_address;
        w_be_nxt      = r_be;
        w_we_nxt      = r_we;
        w_zext_nxt    = r_zext;
        w_size_nxt    = r_size;
        w_lane_nxt    = r_lane;
        w_cnt_nxt     = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_we_nxt   = we;
                    w_zext_nxt = funct3[2];
                    w_size_nxt = funct3[1:0];
                    w_lane_nxt = w_lane;
                    w_mis_nxt  = w_misaligned;
                    w_berr_nxt = 1'b0;
                    w_cnt_nxt  = '0;
                    if (!w_misaligned) begin
                        w_rd_nxt      = !we;
                        w_wr_nxt      = we;
                        w_address_nxt = {addr[ADDR_WIDTH-1:LANE_W], LANE_W'(0)};
                        w_be_nxt      = w_be_mask << w_lane;
                        w_wdata_nxt   = w_wdata_rep;
                    end
                end
            end
            S_REQ: begin
                if (!r_misaligned) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (ack) begin
                        w_rd_nxt = 1'b0;
                        w_wr_nxt = 1'b0;
                        if (!r_we) w_rdata_nxt = w_load;
                    end else if (r_cnt == CNT_LAST) begin
                        w_rd_nxt   = 1'b0;
                        w_wr_nxt   = 1'b0;
                        w_berr_nxt = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign rdata        = r_rdata;
    assign misaligned   = r_misaligned;
    assign bus_error    = r_bus_error;
    assign memory_read  = r_rd;
    assign memory_write = r_wr;
    assign address      = r_address;
    assign write_data   = r_wdata;
    assign byte_enable  = r_be;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a 32-bit and a 64-bit instance
// checked against a transaction-level model of access size, lanes and timing.
`timescale 1ns/1ps
module tb_load_store_unit;
    localparam int T32 = 4;
    localparam int T64 = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, req, we, ack, sel64;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [63:0] wdata, read_data;

    logic        busy32, done32, mis32, berr32, rd32, wr32;
    logic [31:0] rdata32, address32, wdo32;
    logic [3:0]  be32;
    logic        busy64, done64, mis64, berr64, rd64, wr64;
    logic [63:0] rdata64, wdo64;
    logic [31:0] address64;
    logic [7:0]  be64;

    logic        o_busy, o_done, o_mis, o_berr, o_rd, o_wr;
    logic [63:0] o_rdata, o_wdata;
    logic [31:0] o_addr;
    logic [7:0]  o_be;

    int checks = 0;
    int failures = 0;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(T32)) u_lsu32 (
        .clk(clk), .reset(rst_n), .req(req && !sel64), .we(we), .funct3(funct3),
        .addr(addr), .wdata(wdata[31:0]), .busy(busy32), .done(done32), .rdata(rdata32),
        .misaligned(mis32), .bus_error(berr32), .memory_read(rd32), .memory_write(wr32),
        .address(address32), .write_data(wdo32), .byte_enable(be32),
        .read_data(read_data[31:0]), .ack(ack && !sel64));

    load_store_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(T64)) u_lsu64 (
        .clk(clk), .reset(rst_n), .req(req && sel64), .we(we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .busy(busy64), .done(done64), .rdata(rdata64),
        .misaligned(mis64), .bus_error(berr64), .memory_read(rd64), .memory_write(wr64),
        .address(address64), .write_data(wdo64), .byte_enable(be64),
        .read_data(read_data), .ack(ack && sel64));

    assign o_busy  = sel64 ? busy64 : busy32;
    assign o_done  = sel64 ? done64 : done32;
    assign o_mis   = sel64 ? mis64  : mis32;
    assign o_berr  = sel64 ? berr64 : berr32;
    assign o_rd    = sel64 ? rd64   : rd32;
    assign o_wr    = sel64 ? wr64   : wr32;
    assign o_rdata = sel64 ? rdata64 : {32'h0, rdata32};
    assign o_wdata = sel64 ? wdo64   : {32'h0, wdo32};
    assign o_addr  = sel64 ? address64 : address32;
    assign o_be    = sel64 ? be64 : {4'h0, be32};

    // Reference model state: last successful load result per instance
    logic [63:0] m_rdata [2];

    int          obs_strb, obs_acc, obs_done, obs_lat;
    logic        obs_rd, obs_wr, obs_mis, obs_berr, obs_busy1;
    logic [7:0]  obs_be;
    logic [31:0] obs_addr;
    logic [63:0] obs_wdata, obs_rdata;

    int          exp_lat, exp_strb;
    logic        exp_mis, exp_berr;
    logic [7:0]  exp_be;
    logic [31:0] exp_addr;
    logic [63:0] exp_wdata, exp_rdata;

    function automatic int sz_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_misaligned(input bit is64, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = sz_bytes(f3);
        if (!is64 && sz == 8) return 1'b1;
        return (a % sz) != 0;
    endfunction

    function automatic logic [63:0] m_load(input bit is64, input logic [2:0] f3,
                                           input logic [31:0] a, input logic [63:0] rd);
        int nb, sz, lane;
        logic [63:0] v, m;
        nb = is64 ? 8 : 4;
        sz = sz_bytes(f3);
        lane = a % nb;
        if (!is64) rd = rd & 64'hFFFF_FFFF;
        v = rd >> (8 * lane);
        if (sz >= nb) return v;
        m = (64'd1 << (8 * sz)) - 64'd1;
        v = v & m;
        if (!f3[2] && v[8*sz-1]) v = v | ~m;
        if (!is64) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    // One access end to end; expected outcome computed up front from the model
    task automatic run_txn(input bit is64, input logic w, input logic [2:0] f3,
                           input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rd,
                           input int ack_dly, input bit hold);
        int nb, sz, tmo, done_at;
        bit prev_strb;
        nb = is64 ? 8 : 4;
        sz = sz_bytes(f3);
        tmo = is64 ? T64 : T32;
        exp_mis  = m_misaligned(is64, f3, a);
        exp_berr = !exp_mis && (ack_dly >= tmo);
        exp_lat  = exp_mis ? 2 : ((ack_dly < tmo) ? ack_dly + 2 : tmo + 1);
        exp_strb = exp_mis ? 0 : ((ack_dly < tmo) ? ack_dly + 1 : tmo);
        exp_be   = 8'(((1 << sz) - 1) << (a % nb));
        if (!is64) exp_be = exp_be & 8'h0F;
        exp_addr = a & ~32'(nb - 1);
        exp_wdata = '0;
        for (int i = 0; i < nb; i++) exp_wdata[8*i +: 8] = wd[8*(i % sz) +: 8];
        if (!w && !exp_mis && !exp_berr) m_rdata[is64] = m_load(is64, f3, a, rd);
        exp_rdata = m_rdata[is64];

        obs_strb = 0; obs_acc = 0; obs_done = 0; obs_lat = 0;
        obs_rd = 0; obs_wr = 0; obs_mis = 0; obs_berr = 0; obs_busy1 = 0;
        obs_be = '0; obs_addr = '0; obs_wdata = '0; obs_rdata = '0;
        @(negedge clk);
        sel64 = is64; we = w; funct3 = f3; addr = a; wdata = wd; read_data = rd; req = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) req = 1'b0;
        prev_strb = 1'b0;
        done_at = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) obs_busy1 = o_busy;
            if (o_rd || o_wr) begin
                if (!prev_strb) begin
                    obs_acc++;
                    if (obs_acc == 1) begin
                        obs_be = o_be; obs_addr = o_addr; obs_wdata = o_wdata;
                        obs_rd = o_rd; obs_wr = o_wr;
                    end
                end
                ack = (obs_strb == ack_dly);
                obs_strb++;
            end else begin
                ack = 1'b0;
            end
            prev_strb = o_rd || o_wr;
            if (o_done) begin
                obs_done++;
                if (obs_done == 1) begin
                    obs_lat = cyc; obs_rdata = o_rdata; obs_mis = o_mis; obs_berr = o_berr;
                    done_at = cyc;
                end
                req = 1'b0;
            end
            if (done_at != 0 && cyc >= done_at + 3) break;
        end
        ack = 1'b0;
        req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 0; we = 0; ack = 0; sel64 = 0;
        funct3 = '0; addr = '0; wdata = '0; read_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy32, done32, mis32, berr32, rd32, wr32, busy64, done64, mis64, berr64, rd64, wr64} !== 12'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b required 0", {busy32, done32, mis32, berr32, rd32, wr32, busy64, done64, mis64, berr64, rd64, wr64});
        end
        checks++;
        if ({rdata32, address32, wdo32, be32} !== '0) begin
            failures++;
            $display("FAIL reset_bus32: rdata=%h address=%h wdata=%h be=%h required all 0", rdata32, address32, wdo32, be32);
        end
        checks++;
        if ({rdata64, address64, wdo64, be64} !== '0) begin
            failures++;
            $display("FAIL reset_bus64: rdata=%h address=%h wdata=%h be=%h required all 0", rdata64, address64, wdo64, be64);
        end
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_lb_lbu();
        run_txn(1'b0, 1'b0, 3'd0, 32'h103, 64'h0, 64'h80AA_BBCC, 2, 1'b0);
        checks++;
        if (obs_be !== 8'h08) begin failures++; $display("FAIL lb_be: got %h required 08", obs_be); end
        checks++;
        if (obs_addr !== 32'h100) begin failures++; $display("FAIL lb_address: got %h required 00000100", obs_addr); end
        checks++;
        if (obs_rdata !== 64'hFFFF_FF80) begin failures++; $display("FAIL lb_rdata: got %h required ffffff80", obs_rdata); end
        checks++;
        if (obs_done !== 1 || obs_lat !== 4) begin failures++; $display("FAIL lb_done: pulses=%0d latency=%0d required 1 and 4", obs_done, obs_lat); end
        run_txn(1'b0, 1'b0, 3'd4, 32'h103, 64'h0, 64'h80AA_BBCC, 2, 1'b0);
        checks++;
        if (obs_rdata !== 64'h0000_0080) begin failures++; $display("FAIL lbu_rdata: got %h required 00000080", obs_rdata); end
    endtask

    task automatic test_sh();
        run_txn(1'b0, 1'b1, 3'd1, 32'h202, 64'h1234_5678, 64'h0, 0, 1'b0);
        checks++;
        if (obs_wr !== 1'b1 || obs_rd !== 1'b0) begin failures++; $display("FAIL sh_strobes: write=%b read=%b required 1 0", obs_wr, obs_rd); end
        checks++;
        if (obs_be !== 8'h0C) begin failures++; $display("FAIL sh_be: got %h required 0c", obs_be); end
        checks++;
        if (obs_wdata !== 64'h5678_5678) begin failures++; $display("FAIL sh_wdata: got %h required 56785678", obs_wdata); end
        checks++;
        if (obs_lat !== 2 || obs_done !== 1) begin failures++; $display("FAIL sh_latency: got %0d pulses=%0d required 2 and 1", obs_lat, obs_done); end
        checks++;
        if (obs_rdata !== 64'h80) begin failures++; $display("FAIL sh_rdata_kept: got %h required 00000080", obs_rdata); end
    endtask

    task automatic test_misaligned();
        run_txn(1'b0, 1'b0, 3'd2, 32'h201, 64'h0, 64'hFFFF_FFFF, 0, 1'b0);
        checks++;
        if (obs_acc !== 0) begin failures++; $display("FAIL mis_strobes: bus accesses=%0d required 0", obs_acc); end
        checks++;
        if (obs_mis !== 1'b1 || obs_lat !== 2) begin failures++; $display("FAIL mis_done: misaligned=%b latency=%0d required 1 and 2", obs_mis, obs_lat); end
        checks++;
        if (obs_rdata !== 64'h80) begin failures++; $display("FAIL mis_rdata_kept: got %h required 00000080", obs_rdata); end
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 1'b0, 3'd2, 32'h300, 64'h0, 64'h1111_2222, 99, 1'b0);
        checks++;
        if (obs_strb !== 4) begin failures++; $display("FAIL tmo_strobe_cycles: got %0d required 4", obs_strb); end
        checks++;
        if (obs_berr !== 1'b1 || obs_lat !== 5) begin failures++; $display("FAIL tmo_done: bus_error=%b latency=%0d required 1 and 5", obs_berr, obs_lat); end
        checks++;
        if (obs_rdata !== 64'h80) begin failures++; $display("FAIL tmo_rdata_kept: got %h required 00000080", obs_rdata); end
        run_txn(1'b0, 1'b0, 3'd2, 32'h300, 64'h0, 64'h1111_2222, 3, 1'b0);
        checks++;
        if (obs_berr !== 1'b0 || obs_rdata !== 64'h1111_2222) begin failures++; $display("FAIL tmo_ack_on_last: bus_error=%b rdata=%h required 0 11112222", obs_berr, obs_rdata); end
        run_txn(1'b0, 1'b0, 3'd2, 32'h304, 64'h0, 64'h3333_4444, 0, 1'b0);
        checks++;
        if (obs_berr !== 1'b0 || obs_rdata !== 64'h3333_4444) begin failures++; $display("FAIL tmo_cleared: bus_error=%b rdata=%h required 0 33334444", obs_berr, obs_rdata); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge clk);
        sel64 = 1'b0; we = 1'b0; funct3 = 3'd2; addr = 32'h40; read_data = 64'h5555_AAAA; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rd32 !== 1'b1) begin failures++; $display("FAIL rstmid_in_req: memory_read=%b required 1", rd32); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy32, done32, mis32, berr32, rd32, wr32} !== 6'b0 || {rdata32, address32, wdo32, be32} !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs: flags=%b rdata=%h address=%h required all 0", {busy32, done32, mis32, berr32, rd32, wr32}, rdata32, address32);
        end
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done32) seen = 1'b1;
        end
        checks++;
        if (seen) begin failures++; $display("FAIL rstmid_no_done: done seen=%b required 0", seen); end
        run_txn(1'b0, 1'b0, 3'd2, 32'h40, 64'h0, 64'hDEAD_BEEF, 1, 1'b0);
        checks++;
        if (obs_rdata !== 64'hDEAD_BEEF || obs_berr !== 1'b0) begin failures++; $display("FAIL rstmid_fresh_lw: rdata=%h bus_error=%b required deadbeef 0", obs_rdata, obs_berr); end
    endtask

    task automatic test_ld64();
        run_txn(1'b1, 1'b0, 3'd3, 32'h8, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 1'b1);
        checks++;
        if (obs_be !== 8'hFF) begin failures++; $display("FAIL ld64_be: got %h required ff", obs_be); end
        checks++;
        if (obs_rdata !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("FAIL ld64_rdata: got %h required 0123456789abcdef", obs_rdata); end
        checks++;
        if (obs_acc !== 1 || obs_done !== 1) begin failures++; $display("FAIL ld64_req_held: accesses=%0d pulses=%0d required 1 and 1", obs_acc, obs_done); end
        run_txn(1'b1, 1'b0, 3'd2, 32'h0C, 64'h0, 64'h8000_0000_0000_0000, 0, 1'b0);
        checks++;
        if (obs_rdata !== 64'hFFFF_FFFF_8000_0000) begin failures++; $display("FAIL lw64_sext: got %h required ffffffff80000000", obs_rdata); end
        run_txn(1'b0, 1'b0, 3'd3, 32'h8, 64'h0, 64'h1, 0, 1'b0);
        checks++;
        if (obs_mis !== 1'b1 || obs_acc !== 0) begin failures++; $display("FAIL ld32_mis: misaligned=%b accesses=%0d required 1 and 0", obs_mis, obs_acc); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            bit          is64;
            logic        w;
            logic [2:0]  f3;
            logic [31:0] a;
            logic [63:0] wd, rd;
            int          dly;
            is64 = 1'($urandom_range(0, 1));
            w    = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            a    = 32'($urandom) & 32'h0000_0FFF;
            wd   = {32'($urandom), 32'($urandom)};
            rd   = {32'($urandom), 32'($urandom)};
            dly  = $urandom_range(0, 7);
            run_txn(is64, w, f3, a, wd, rd, dly, 1'b0);
            checks++;
            if (obs_done !== 1 || obs_lat !== exp_lat || obs_busy1 !== 1'b1) begin
                failures++;
                $display("FAIL rnd%0d_timing: pulses=%0d latency=%0d busy=%b required 1 %0d 1", i, obs_done, obs_lat, obs_busy1, exp_lat);
            end
            checks++;
            if (obs_mis !== exp_mis || obs_berr !== exp_berr) begin
                failures++;
                $display("FAIL rnd%0d_flags: misaligned=%b bus_error=%b required %b %b", i, obs_mis, obs_berr, exp_mis, exp_berr);
            end
            checks++;
            if (obs_rdata !== exp_rdata) begin
                failures++;
                $display("FAIL rnd%0d_rdata: got %h required %h (w=%b f3=%0d a=%h)", i, obs_rdata, exp_rdata, w, f3, a);
            end
            checks++;
            if (obs_strb !== exp_strb || obs_acc !== (exp_mis ? 0 : 1)) begin
                failures++;
                $display("FAIL rnd%0d_strobes: cycles=%0d accesses=%0d required %0d %0d", i, obs_strb, obs_acc, exp_strb, exp_mis ? 0 : 1);
            end
            if (!exp_mis) begin
                checks++;
                if (obs_be !== exp_be || obs_addr !== exp_addr || obs_rd !== !w || obs_wr !== w) begin
                    failures++;
                    $display("FAIL rnd%0d_bus: be=%h address=%h rd=%b wr=%b required %h %h %b %b", i, obs_be, obs_addr, obs_rd, obs_wr, exp_be, exp_addr, !w, w);
                end
                if (w) begin
                    checks++;
                    if (obs_wdata !== exp_wdata) begin
                        failures++;
                        $display("FAIL rnd%0d_wdata: got %h required %h", i, obs_wdata, exp_wdata);
                    end
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lb_lbu();
        test_sh();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_ld64();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle load/store unit between the core datapath and the memory bus.
- Replaces the core's fixed single-word, no-handshake memory access with:
  - a parametrised data width;
  - byte/half/word(/double) accesses with sign or zero extension;
  - byte enables;
  - misalignment detection;
  - an ack handshake with a timeout.
- The core issues one request, waits on `busy`, and takes the result when `done` pulses.

Parameters:
- DATA_WIDTH, 32, bus/data width in bits; legal values 32 or 64.
- ADDR_WIDTH, 32, address width in bits.
- TIMEOUT_CYCLES, 255, cycles to wait for ack before flagging bus_error; legal range 1..65535.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  core request strobe; sampled only in IDLE.
- we  input  1  1 = store, 0 = load.
- funct3  input  3  bits[1:0]: size (0 = B, 1 = H, 2 = W, 3 = D); bit[2]: 1 = zero-extend load.
- addr  input  ADDR_WIDTH  byte address.
- wdata  input  DATA_WIDTH  store data, right-aligned.
- busy  output  1  high while a request is in flight (not IDLE).
- done  output  1  one-cycle completion pulse.
- rdata  output  DATA_WIDTH  extended load result; held until the next done.
- misaligned  output  1  valid with done; access was not naturally aligned.
- bus_error  output  1  valid with done; ack timeout occurred.
- memory_read  output  1  bus read strobe.
- memory_write  output  1  bus write strobe.
- address  output  ADDR_WIDTH  addr with its low log2(DATA_WIDTH/8) bits forced to 0.
- write_data  output  DATA_WIDTH  store data replicated across lanes.
- byte_enable  output  DATA_WIDTH/8  active lanes.
- read_data  input  DATA_WIDTH  bus read data; valid when ack = 1.
- ack  input  1  bus completion; ignored outside REQ.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE.
  - All outputs 0, including rdata.
  - Timeout counter cleared.
  - Reset mid-transfer abandons the access; no done is produced.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - On req = 1, latch we, funct3, addr and wdata.
  - If misaligned: go to DONE with misaligned = 1. No bus strobe is ever asserted.
  - Otherwise: go to REQ and assert memory_read (we = 0) or memory_write (we = 1) together with address, byte_enable and write_data, all registered.
- Misalignment rule:
  - H needs addr[0] = 0.
  - W needs addr[1:0] = 0.
  - D needs addr[2:0] = 0.
  - D with DATA_WIDTH = 32 is treated as misaligned.
- REQ:
  - Strobes are held stable.
  - Counter increments each cycle.
  - On ack = 1:
    - Loads capture the extended result into rdata.
    - Strobes drop at the next edge.
    - Go to DONE.
  - If the counter reaches TIMEOUT_CYCLES without ack:
    - Drop strobes, set bus_error = 1, go to DONE.
    - rdata is unchanged.
  - An ack arriving in the same cycle the count is reached wins; bus_error stays 0.
- DONE:
  - done = 1 for exactly one cycle, then IDLE.
  - misaligned and bus_error are cleared when the next request is accepted.
- busy:
  - 1 in REQ and DONE.
  - req is ignored while busy = 1.
  - A new req is accepted in the cycle after done.
- Latency:
  - req sampled at edge N; strobes visible after N.
  - ack in that cycle gives done high after edge N+1. Minimum two cycles from req to done.
  - Misaligned requests: done after edge N+1 as well.
- Lane / byte_enable:
  - lane = addr[log2(DATA_WIDTH/8)-1:0].
  - byte_enable = (B: 1, H: 3, W: 0xF, D: 0xFF) shifted left by lane.
- write_data: B, H and W data replicated across the bus width.
- Load extraction:
  - Take read_data >> (8 × lane), truncated to the access size.
  - Sign-extend when funct3[2] = 0, zero-extend when funct3[2] = 1.
  - Loads of the full DATA_WIDTH are passed through unchanged.
- Stores leave rdata unchanged.

Test Plan:
- LB, DATA_WIDTH = 32: addr = 0x103, read_data = 0x80AA_BBCC, ack 2 cycles after strobe.
  - Required: byte_enable = 0x8, address = 0x100, rdata = 0xFFFF_FF80, done pulses once.
  - Same access as LBU (funct3 = 4): rdata = 0x0000_0080.
- SH: addr = 0x202, wdata = 0x1234_5678, ack immediately.
  - Required: memory_write = 1, byte_enable = 0xC, write_data = 0x5678_5678, done two cycles after req.
- LW at addr = 0x201.
  - Required: memory_read and memory_write stay 0, done with misaligned = 1, rdata unchanged.
- TIMEOUT_CYCLES = 4, ack never asserted.
  - Required: strobes drop after 4 cycles in REQ, done with bus_error = 1.
  - Required: the next good LW clears bus_error.
- reset pulled low mid-REQ, then released.
  - Required: all outputs 0 immediately, no done.
  - Required: a fresh LW (read_data = 0xDEAD_BEEF) returns rdata = 0xDEAD_BEEF.
- DATA_WIDTH = 64, LD: addr = 0x8, read_data = 0x0123_4567_89AB_CDEF.
  - Required: byte_enable = 0xFF, rdata passed through unchanged.
  - Also: a req held high during busy is ignored (exactly one bus access).
